// File: rtl/fwd_hazard_unit_if.sv
// fwd_hazard_unit_if
//   Bundles the pipeline-side signals of the forwarding/hazard unit.
//   master : pipeline control (drives ID/EX/producer-stage info, reads results)
//   slave  : fwd_hazard_unit (reads stage info, drives id_ready/forwarding/stall count)
//   Signals:
//     flush, id_valid, id_rs[NSRC*5]      - ID stage instruction info
//     id_ready                            - ID may advance this cycle
//     ex_wr, ex_we, ex_load               - instruction currently in EX
//     stg_wr, stg_we, stg_ok, stg_data    - producer stages older than EX (0 = MEM)
//     fwd_en, fwd_data, fwd_pend          - per-source forwarding result
//     stall_cnt                           - saturating load-use stall cycle count
interface fwd_hazard_unit_if #(
  parameter int XLEN = 32,
  parameter int NSRC = 2,
  parameter int NSTG = 3
);
  logic                 flush;
  logic                 id_valid;
  logic [NSRC*5-1:0]    id_rs;
  logic                 id_ready;
  logic [4:0]           ex_wr;
  logic                 ex_we;
  logic                 ex_load;
  logic [NSTG*5-1:0]    stg_wr;
  logic [NSTG-1:0]      stg_we;
  logic [NSTG-1:0]      stg_ok;
  logic [NSTG*XLEN-1:0] stg_data;
  logic [NSRC-1:0]      fwd_en;
  logic [NSRC*XLEN-1:0] fwd_data;
  logic [NSRC-1:0]      fwd_pend;
  logic [31:0]          stall_cnt;

  modport master (
    output flush, id_valid, id_rs, ex_wr, ex_we, ex_load,
           stg_wr, stg_we, stg_ok, stg_data,
    input  id_ready, fwd_en, fwd_data, fwd_pend, stall_cnt
  );

  modport slave (
    input  flush, id_valid, id_rs, ex_wr, ex_we, ex_load,
           stg_wr, stg_we, stg_ok, stg_data,
    output id_ready, fwd_en, fwd_data, fwd_pend, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   Operand-forwarding and load-use hazard unit for the in-order pipeline.
//   Latches the ID source indices into an EX-stage register when ID advances,
//   then picks (combinationally) the youngest producer stage whose destination
//   matches each EX source. Detects load-use hazards in ID, holds ID for
//   LOAD_LAT cycles and counts the stall cycles (saturating).
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous active-high reset
//     bus  - fwd_hazard_unit_if.slave (ID/EX/stage inputs, forwarding outputs)
module fwd_hazard_unit #(
  parameter int XLEN     = 32,
  parameter int NSRC     = 2,
  parameter int NSTG     = 3,
  parameter int LOAD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  fwd_hazard_unit_if.slave bus
);

  localparam int CW = $clog2(LOAD_LAT + 1);

  typedef enum logic {RUN, STALL} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   ex_vld_q, ex_vld_d;
  logic [NSRC-1:0][4:0]   ex_rs_q, ex_rs_d;
  logic [31:0]            stall_cnt_q, stall_cnt_d;

  logic                   hit_lu;
  logic                   id_ready;
  logic                   stall_inc;
  logic                   advance;
  logic [NSRC-1:0]        rs_match;

  logic [NSRC-1:0]            fwd_en_w;
  logic [NSRC-1:0][XLEN-1:0]  fwd_data_w;
  logic [NSRC-1:0]            fwd_pend_w;

  // Load-use detection against the load currently in EX.
  // ex_wr != 0 also keeps x0 sources from ever matching.
  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_lu
      assign rs_match[gi] = (bus.id_rs[5*gi +: 5] == bus.ex_wr);
    end
  endgenerate

  assign hit_lu = bus.id_valid & bus.ex_load & bus.ex_we &
                  (bus.ex_wr != 5'd0) & (|rs_match);

  // Next-state / output logic. flush overrides the hazard FSM entirely.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    id_ready  = 1'b1;
    stall_inc = 1'b0;
    if (bus.flush) begin
      id_ready = 1'b0;
      state_d  = RUN;
      cnt_d    = '0;
    end else begin
      case (state_q)
        RUN: begin
          id_ready = ~hit_lu;
          if (hit_lu) begin
            stall_inc = 1'b1;
            // A single-cycle stall needs no extra state: the bubble
            // inserted this cycle removes the load from EX next cycle.
            if (LOAD_LAT > 1) begin
              state_d = STALL;
              cnt_d   = CW'(LOAD_LAT - 1);
            end
          end
        end
        STALL: begin
          id_ready  = 1'b0;
          stall_inc = 1'b1;
          cnt_d     = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // EX register: capture on advance, otherwise insert a bubble.
  assign advance  = bus.id_valid & id_ready;
  assign ex_vld_d = advance;
  assign ex_rs_d  = advance ? bus.id_rs : '0;

  assign stall_cnt_d = (stall_inc && (stall_cnt_q != 32'hFFFF_FFFF)) ?
                       stall_cnt_q + 32'd1 : stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      ex_vld_q    <= 1'b0;
      ex_rs_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ex_vld_q    <= ex_vld_d;
      ex_rs_q     <= ex_rs_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Forwarding select per source. Scanning from the oldest stage down to
  // the youngest lets the youngest matching stage overwrite older ones.
  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_fwd
      logic            en_s;
      logic [XLEN-1:0] data_s;
      logic            pend_s;

      always_comb begin
        en_s   = 1'b0;
        data_s = '0;
        pend_s = 1'b0;
        for (int k = NSTG - 1; k >= 0; k--) begin
          if (ex_vld_q && (ex_rs_q[gi] != 5'd0) && bus.stg_we[k] &&
              (bus.stg_wr[5*k +: 5] == ex_rs_q[gi])) begin
            en_s   = 1'b1;
            data_s = bus.stg_data[XLEN*k +: XLEN];
            pend_s = ~bus.stg_ok[k];
          end
        end
      end

      assign fwd_en_w[gi]   = en_s;
      assign fwd_data_w[gi] = data_s;
      assign fwd_pend_w[gi] = pend_s;
    end
  endgenerate

  assign bus.id_ready  = id_ready;
  assign bus.fwd_en    = fwd_en_w;
  assign bus.fwd_data  = fwd_data_w;
  assign bus.fwd_pend  = fwd_pend_w;
  assign bus.stall_cnt = stall_cnt_q;

endmodule
